// File: rtl/prog_clock_div.sv
// rtl/prog_clock_div.sv - multi-channel programmable integer clock divider
module prog_clock_div #(
  parameter int NCH         = 2,
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   en,
  input  logic [NCH*W-1:0] div_val,
  input  logic [NCH-1:0]   div_load,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   pending
);

  typedef enum logic {IDLE, RUN} state_t;

  // Reset divisor, clamped so a bad parameter can never stall a channel.
  localparam logic [W-1:0] DEF_N = (DEFAULT_DIV < 2) ? W'(2) : W'(DEFAULT_DIV);

  state_t         state_q [NCH];
  state_t         state_d [NCH];
  logic [W-1:0]   cnt_q   [NCH];
  logic [W-1:0]   cnt_d   [NCH];
  logic [W-1:0]   n_q     [NCH];
  logic [W-1:0]   n_d     [NCH];
  logic [W-1:0]   pv_q    [NCH];
  logic [W-1:0]   pv_d    [NCH];
  logic [W-1:0]   ld_val  [NCH];
  logic [W-1:0]   eff_n   [NCH];
  logic [W:0]     half    [NCH];
  logic [W:0]     cnt_inc [NCH];
  logic [NCH-1:0] clk_d;
  logic [NCH-1:0] tick_d;
  logic [NCH-1:0] pend_d;

  // Divisors 0 and 1 cannot produce a clock, so they are stored as 2.
  function automatic logic [W-1:0] clamp_div(input logic [W-1:0] v);
    return (v < W'(2)) ? W'(2) : v;
  endfunction

  // Per-channel state and output registers; reset discards pending divisors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        n_q[i]     <= DEF_N;
        pv_q[i]    <= DEF_N;
      end
      clk_out <= '0;
      tick    <= '0;
      pending <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        n_q[i]     <= n_d[i];
        pv_q[i]    <= pv_d[i];
      end
      clk_out <= clk_d;
      tick    <= tick_d;
      pending <= pend_d;
    end
  end

  // Next-state logic: divisor changes only land at period boundaries or at start.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      n_d[i]     = n_q[i];
      pv_d[i]    = pv_q[i];
      pend_d[i]  = pending[i];
      clk_d[i]   = clk_out[i];
      tick_d[i]  = 1'b0;

      ld_val[i]  = clamp_div(div_val[i*W +: W]);
      // A load in the same cycle as a boundary wins over an older pending value.
      eff_n[i]   = div_load[i] ? ld_val[i] : (pending[i] ? pv_q[i] : n_q[i]);
      // High phase is ceil(N/2); one extra bit keeps N=2^W-1 from overflowing.
      half[i]    = ({1'b0, n_q[i]} + {{W{1'b0}}, 1'b1}) >> 1;
      cnt_inc[i] = {1'b0, cnt_q[i]} + {{W{1'b0}}, 1'b1};

      case (state_q[i])
        IDLE: begin
          clk_d[i] = 1'b0;
          cnt_d[i] = '0;
          if (en[i]) begin
            n_d[i]     = eff_n[i];
            pend_d[i]  = 1'b0;
            state_d[i] = RUN;
            clk_d[i]   = 1'b1;
            tick_d[i]  = 1'b1;
          end else if (div_load[i]) begin
            pv_d[i]   = ld_val[i];
            pend_d[i] = 1'b1;
          end
        end
        RUN: begin
          if (cnt_q[i] == n_q[i] - W'(1)) begin
            n_d[i]    = eff_n[i];
            pend_d[i] = 1'b0;
            cnt_d[i]  = '0;
            if (en[i]) begin
              clk_d[i]  = 1'b1;
              tick_d[i] = 1'b1;
            end else begin
              state_d[i] = IDLE;
              clk_d[i]   = 1'b0;
            end
          end else begin
            cnt_d[i] = cnt_q[i] + W'(1);
            clk_d[i] = (cnt_inc[i] < half[i]);
            if (div_load[i]) begin
              pv_d[i]   = ld_val[i];
              pend_d[i] = 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_clock_div.sv
// tb/tb_prog_clock_div.sv - self-checking bench for prog_clock_div
module tb_prog_clock_div;

  localparam int NCH = 2;
  localparam int W   = 8;

  logic             clk;
  logic             rst_n;
  logic [NCH-1:0]   en;
  logic [NCH*W-1:0] div_val;
  logic [NCH-1:0]   div_load;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   pending;

  prog_clock_div #(.NCH(NCH), .W(W), .DEFAULT_DIV(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .clk_out  (clk_out),
    .tick     (tick),
    .pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: {clk_out[1:0], tick[1:0], pending[1:0]}
  typedef struct {
    logic [1:0] en;
    logic [1:0] ld;
    logic [7:0] dv0;
    logic [7:0] dv1;
    logic [5:0] exp_v;
  } vec_t;

  typedef struct {
    logic [5:0] v;
    logic [5:0] m;
  } exp_t;

  localparam logic [5:0] ALL = 6'b111111;
  localparam logic [5:0] CH0 = 6'b010101;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic add(input logic [1:0] e, input logic [1:0] l,
                     input logic [7:0] d0, input logic [7:0] d1, input logic [5:0] ev);
    vec_t r;
    r.en = e; r.ld = l; r.dv0 = d0; r.dv1 = d1; r.exp_v = ev;
    vecs.push_back(r);
  endtask

  task automatic compare(input string nm, input logic [5:0] ev, input logic [5:0] m);
    logic [5:0] got;
    got = {clk_out, tick, pending};
    checks++;
    if ((got & m) !== (ev & m)) begin
      failures++;
      $display("FAIL %s: got clk_out/tick/pending=%b required=%b (mask %b)", nm, got, ev, m);
    end
  endtask

  task automatic step(input logic [1:0] e, input logic [1:0] l,
                      input logic [7:0] d0, input logic [7:0] d1,
                      input logic [5:0] ev, input logic [5:0] m, input string nm);
    exp_t x;
    @(negedge clk);
    en = e; div_load = l; div_val = {d1, d0};
    x.v = ev; x.m = m;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty got=%b required=%b", nm, {clk_out, tick, pending}, ev);
    end else begin
      x = exp_q.pop_front();
      compare(nm, x.v, x.m);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = '0; div_load = '0; div_val = '0;

    // ch0 /2, ch1 load 3 while idle then run, ch1 stop, ch0 4->6, 5 with en drop, clamp 0/1
    add(2'b01, 2'b00, 8'd0, 8'd0, 6'b01_01_00);
    add(2'b01, 2'b00, 8'd0, 8'd0, 6'b00_00_00);
    add(2'b01, 2'b00, 8'd0, 8'd0, 6'b01_01_00);
    add(2'b01, 2'b00, 8'd0, 8'd0, 6'b00_00_00);
    add(2'b01, 2'b10, 8'd0, 8'd3, 6'b01_01_10);
    add(2'b11, 2'b00, 8'd0, 8'd0, 6'b10_10_00);
    add(2'b11, 2'b00, 8'd0, 8'd0, 6'b11_01_00);
    add(2'b11, 2'b00, 8'd0, 8'd0, 6'b00_00_00);
    add(2'b11, 2'b00, 8'd0, 8'd0, 6'b11_11_00);
    add(2'b11, 2'b00, 8'd0, 8'd0, 6'b10_00_00);
    add(2'b11, 2'b00, 8'd0, 8'd0, 6'b01_01_00);
    add(2'b11, 2'b00, 8'd0, 8'd0, 6'b10_10_00);
    add(2'b01, 2'b00, 8'd0, 8'd0, 6'b11_01_00);
    add(2'b01, 2'b00, 8'd0, 8'd0, 6'b00_00_00);
    add(2'b01, 2'b00, 8'd0, 8'd0, 6'b01_01_00);
    add(2'b01, 2'b00, 8'd0, 8'd0, 6'b00_00_00);
    add(2'b01, 2'b01, 8'd4, 8'd0, 6'b01_01_00);
    add(2'b01, 2'b01, 8'd6, 8'd0, 6'b01_00_01);
    add(2'b01, 2'b00, 8'd0, 8'd0, 6'b00_00_01);
    add(2'b01, 2'b00, 8'd0, 8'd0, 6'b00_00_01);
    add(2'b01, 2'b00, 8'd0, 8'd0, 6'b01_01_00);
    add(2'b01, 2'b00, 8'd0, 8'd0, 6'b01_00_00);
    add(2'b01, 2'b00, 8'd0, 8'd0, 6'b01_00_00);
    add(2'b01, 2'b00, 8'd0, 8'd0, 6'b00_00_00);
    add(2'b01, 2'b00, 8'd0, 8'd0, 6'b00_00_00);
    add(2'b01, 2'b00, 8'd0, 8'd0, 6'b00_00_00);
    add(2'b01, 2'b00, 8'd0, 8'd0, 6'b01_01_00);
    add(2'b01, 2'b00, 8'd0, 8'd0, 6'b01_00_00);
    add(2'b01, 2'b00, 8'd0, 8'd0, 6'b01_00_00);
    add(2'b01, 2'b00, 8'd0, 8'd0, 6'b00_00_00);
    add(2'b01, 2'b00, 8'd0, 8'd0, 6'b00_00_00);
    add(2'b01, 2'b00, 8'd0, 8'd0, 6'b00_00_00);
    add(2'b01, 2'b01, 8'd5, 8'd0, 6'b01_01_00);
    add(2'b01, 2'b00, 8'd0, 8'd0, 6'b01_00_00);
    add(2'b00, 2'b00, 8'd0, 8'd0, 6'b01_00_00);
    add(2'b00, 2'b00, 8'd0, 8'd0, 6'b00_00_00);
    add(2'b00, 2'b00, 8'd0, 8'd0, 6'b00_00_00);
    add(2'b00, 2'b00, 8'd0, 8'd0, 6'b00_00_00);
    add(2'b00, 2'b00, 8'd0, 8'd0, 6'b00_00_00);
    add(2'b01, 2'b00, 8'd0, 8'd0, 6'b01_01_00);
    add(2'b01, 2'b10, 8'd0, 8'd0, 6'b01_00_10);
    add(2'b01, 2'b10, 8'd0, 8'd1, 6'b01_00_10);
    add(2'b11, 2'b00, 8'd0, 8'd0, 6'b10_10_00);
    add(2'b11, 2'b00, 8'd0, 8'd0, 6'b00_00_00);
    add(2'b11, 2'b00, 8'd0, 8'd0, 6'b11_11_00);
    add(2'b11, 2'b00, 8'd0, 8'd0, 6'b01_00_00);

    repeat (2) @(negedge clk);
    compare("reset_state", 6'b000000, ALL);
    rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++)
      step(vecs[k].en, vecs[k].ld, vecs[k].dv0, vecs[k].dv1, vecs[k].exp_v, ALL,
           $sformatf("vec%0d", k));

    // Last load before the boundary wins: 255 then 7 -> period 7, high 4 cycles
    step(2'b01, 2'b01, 8'd255, 8'd0, 6'b01_00_01, CH0, "load255_pending");
    step(2'b01, 2'b01, 8'd7,   8'd0, 6'b00_00_01, CH0, "load7_pending");
    step(2'b01, 2'b00, 8'd0,   8'd0, 6'b00_00_01, CH0, "n5_tail");
    step(2'b01, 2'b00, 8'd0,   8'd0, 6'b01_01_00, CH0, "n7_start");
    for (int k = 1; k <= 7; k++)
      step(2'b01, 2'b00, 8'd0, 8'd0,
           {1'b0, (k < 4) || (k == 7), 1'b0, (k == 7), 1'b0, 1'b0}, CH0,
           $sformatf("n7_cycle%0d", k));

    // Async reset mid-period with a pending divisor
    @(negedge clk); rst_n = 1'b0; en = '0; div_load = '0;
    @(negedge clk); rst_n = 1'b1;
    step(2'b01, 2'b01, 8'd6, 8'd0, 6'b01_01_00, ALL, "n6_start");
    step(2'b01, 2'b00, 8'd0, 8'd0, 6'b01_00_00, ALL, "n6_cnt1");
    step(2'b01, 2'b01, 8'd9, 8'd0, 6'b01_00_01, ALL, "n6_cnt2_pending");
    @(negedge clk); rst_n = 1'b0;
    #1;
    compare("async_reset", 6'b000000, ALL);
    en = '0; div_load = '0;
    @(negedge clk); rst_n = 1'b1;
    step(2'b01, 2'b00, 8'd0, 8'd0, 6'b01_01_00, ALL, "post_reset_c1");
    step(2'b01, 2'b00, 8'd0, 8'd0, 6'b00_00_00, ALL, "post_reset_c2");
    step(2'b01, 2'b00, 8'd0, 8'd0, 6'b01_01_00, ALL, "post_reset_c3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
